// File: rtl/cpu31_pkg.sv
// Shared constants for the CPU31 core: reset vector, datapath widths and the NOP word.
package cpu31_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
   localparam int          INSTR_W          = 32;
   localparam int          IMEM_ADDR_W      = 11;
   localparam logic [INSTR_W-1:0] NOP_WORD  = 32'h0000_0000;

   typedef enum logic [1:0] {
      PC_HOLD     = 2'd0,
      PC_INC      = 2'd1,
      PC_REDIRECT = 2'd2
   } pc_sel_e;

endpackage

// File: rtl/if_pc_reg.sv
// Program counter with redirect/+4/hold next-PC mux and ROM-range legality check.
import cpu31_pkg::*;

module if_pc_reg #(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          ADDR_W   = IMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   input  logic              advance,
   output logic [31:0]       pc_q,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              bad
);

   // ROM size in bytes, held in 33 bits so the compare stays exact for any ADDR_W.
   localparam logic [32:0] ROM_BYTES = 33'd4 << ADDR_W;

   logic [31:0] off;
   pc_sel_e     pc_sel;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      off       = pc_q - RESET_PC;
      imem_addr = off[ADDR_W+1:2];
      bad       = (pc_q[1:0] != 2'b00) || ({1'b0, off} >= ROM_BYTES);
      pc_sel    = PC_HOLD;
      if (redirect_valid)
         pc_sel = PC_REDIRECT;
      else if (advance)
         pc_sel = PC_INC;
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (!rst_n)
         pc_q <= RESET_PC;
      else begin
         unique case (pc_sel)
            PC_REDIRECT: pc_q <= redirect_pc;
            PC_INC:      pc_q <= pc_q + 32'd4;
            default:     pc_q <= pc_q;
         endcase
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// CPU31 instruction-fetch stage: PC, IMEM address, IF/ID register with valid/ready to decode.
// Optional performance counters compiled in with `define IF_PERF_CNT_EN.
import cpu31_pkg::*;

module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          ADDR_W   = IMEM_ADDR_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_instr,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [31:0]        id_pc,
   output logic [INSTR_W-1:0] id_instr,
`ifdef IF_PERF_CNT_EN
   output logic [31:0]        perf_fetch_cnt,
   output logic [31:0]        perf_stall_cnt,
`endif
   output logic               fetch_fault
);

   logic [31:0] pc_q;
   logic        bad;
   logic        slot_free;
   logic        load;

   assign slot_free = !id_valid || id_ready;
   assign load      = !redirect_valid && !fetch_fault && !bad && slot_free;

   if_pc_reg #(
      .RESET_PC (RESET_PC),
      .ADDR_W   (ADDR_W)
   ) u_pc_reg (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .advance        (load),
      .pc_q           (pc_q),
      .imem_addr      (imem_addr),
      .bad            (bad)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         id_valid    <= 1'b0;
         id_pc       <= 32'd0;
         id_instr    <= NOP_WORD;
         fetch_fault <= 1'b0;
      end else if (redirect_valid) begin
         // The word fetched this cycle belongs to the wrong path and is dropped.
         id_valid    <= 1'b0;
         fetch_fault <= 1'b0;
      end else begin
         if (load) begin
            id_valid <= 1'b1;
            id_pc    <= pc_q;
            id_instr <= imem_instr;
         end else if (id_valid && id_ready) begin
            id_valid <= 1'b0;
         end
         if (bad && slot_free)
            fetch_fault <= 1'b1;
      end
   end

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_fetch_cnt <= 32'd0;
         perf_stall_cnt <= 32'd0;
      end else begin
         if (load)
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (id_valid && !id_ready)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a behavioural ROM holding ROM[k] = k+1.
module tb_if_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [10:0] imem_addr;
   logic [31:0] imem_instr;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        fetch_fault;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   assign imem_instr = 32'(imem_addr) + 32'd1;

   if_fetch_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_pc          (id_pc),
      .id_instr       (id_instr),
`ifdef IF_PERF_CNT_EN
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt),
`endif
      .fetch_fault    (fetch_fault)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_id(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
      check({tag, ".valid"}, 32'(id_valid), 32'(v));
      check({tag, ".pc"}, id_pc, pc);
      check({tag, ".instr"}, id_instr, ins);
   endtask

   initial begin
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; id_ready = 1'b0;
      step(); step();
      chk_id("reset", 1'b0, 32'd0, 32'd0);
      check("reset.fault", 32'(fetch_fault), 32'd0);
      check("reset.addr", 32'(imem_addr), 32'd0);
      check("reset.pc", dut.u_pc_reg.pc_q, RST_PC);

      // Streaming fetch, one word per cycle
      rst_n = 1'b1; id_ready = 1'b1;
      step(); chk_id("s0", 1'b1, 32'h0040_0000, 32'd1);
      step(); chk_id("s1", 1'b1, 32'h0040_0004, 32'd2);
      step(); chk_id("s2", 1'b1, 32'h0040_0008, 32'd3);
      step(); chk_id("s3", 1'b1, 32'h0040_000C, 32'd4);

      // Restart at reset vector, then stall after id_pc=0x00400004
      redirect_valid = 1'b1; redirect_pc = RST_PC;
      step(); check("rd0.valid", 32'(id_valid), 32'd0);
      redirect_valid = 1'b0;
      step(); chk_id("rd0.a", 1'b1, 32'h0040_0000, 32'd1);
      step(); chk_id("rd0.b", 1'b1, 32'h0040_0004, 32'd2);
      id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_id("stall", 1'b1, 32'h0040_0004, 32'd2);
         check("stall.addr", 32'(imem_addr), 32'd2);
      end
      id_ready = 1'b1;
      step(); chk_id("release", 1'b1, 32'h0040_0008, 32'd3);
`ifdef IF_PERF_CNT_EN
      check("perf.fetch", perf_fetch_cnt, 32'd7);
      check("perf.stall", perf_stall_cnt, 32'd3);
`endif

      // Redirect during a stall flushes IF/ID
      id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0040_0040;
      step(); check("rd40.flush", 32'(id_valid), 32'd0);
      redirect_valid = 1'b0;
      step(); chk_id("rd40", 1'b1, 32'h0040_0040, 32'd17);

      // Misaligned target faults; realigned redirect clears and resumes
      id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0040_0002;
      step(); check("mis.valid0", 32'(id_valid), 32'd0);
      check("mis.fault0", 32'(fetch_fault), 32'd0);
      redirect_valid = 1'b0;
      step(); check("mis.fault1", 32'(fetch_fault), 32'd1);
      check("mis.valid1", 32'(id_valid), 32'd0);
      step(); check("mis.hold", dut.u_pc_reg.pc_q, 32'h0040_0002);
      check("mis.valid2", 32'(id_valid), 32'd0);
      redirect_valid = 1'b1; redirect_pc = RST_PC;
      step(); check("clr.fault", 32'(fetch_fault), 32'd0);
      redirect_valid = 1'b0;
      step(); chk_id("clr.resume", 1'b1, 32'h0040_0000, 32'd1);

      // Last ROM word delivered, then fault at the end of the ROM
      redirect_valid = 1'b1; redirect_pc = 32'h0040_1FFC;
      step(); check("last.flush", 32'(id_valid), 32'd0);
      redirect_valid = 1'b0;
      step(); chk_id("last", 1'b1, 32'h0040_1FFC, 32'd2048);
      check("last.nofault", 32'(fetch_fault), 32'd0);
      step(); check("end.fault", 32'(fetch_fault), 32'd1);
      check("end.drain", 32'(id_valid), 32'd0);
      check("end.pc", dut.u_pc_reg.pc_q, 32'h0040_2000);
      step(); check("end.pc_hold", dut.u_pc_reg.pc_q, 32'h0040_2000);

      // Target below the reset vector wraps to a huge offset
      redirect_valid = 1'b1; redirect_pc = 32'h003F_FFFC;
      step(); redirect_valid = 1'b0;
      step(); check("low.fault", 32'(fetch_fault), 32'd1);
      check("low.valid", 32'(id_valid), 32'd0);

      // Reset mid-stall overrides a simultaneous redirect
      redirect_valid = 1'b1; redirect_pc = RST_PC + 32'h10;
      step(); redirect_valid = 1'b0;
      step(); chk_id("pre_rst", 1'b1, 32'h0040_0010, 32'd5);
      id_ready = 1'b0;
      step(); check("pre_rst.stall", 32'(id_valid), 32'd1);
      rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
      step();
      chk_id("mid_rst", 1'b0, 32'd0, 32'd0);
      check("mid_rst.pc", dut.u_pc_reg.pc_q, RST_PC);
      check("mid_rst.fault", 32'(fetch_fault), 32'd0);
`ifdef IF_PERF_CNT_EN
      check("mid_rst.fetch", perf_fetch_cnt, 32'd0);
      check("mid_rst.stall", perf_stall_cnt, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
